// File: rtl/tube_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: frame-aligned input snapshot,
// optional leading-zero blanking and per-digit blinking on a shared segment bus.
module tube_scan_driver #(
    parameter int unsigned   CLK_FREQ  = 100000000,
    parameter int unsigned   SCAN_HZ   = 1000,
    parameter int unsigned   BLINK_HZ  = 2,
    parameter int unsigned   TUBE_BITS = 8,
    parameter logic [TUBE_BITS-1:0] SEG_ZERO = 8'hc0,
    parameter logic [TUBE_BITS-1:0] SEG_EMP  = 8'hff
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TUBE_BITS-1:0] l0,
    input  logic [TUBE_BITS-1:0] l1,
    input  logic [TUBE_BITS-1:0] l2,
    input  logic [TUBE_BITS-1:0] l3,
    input  logic [TUBE_BITS-1:0] l4,
    input  logic [TUBE_BITS-1:0] l5,
    input  logic [TUBE_BITS-1:0] l6,
    input  logic [TUBE_BITS-1:0] l7,
    input  logic                 scan_en,
    input  logic                 lz_en,
    input  logic [7:0]           blink_mask,
    output logic [7:0]           tube_sel,
    output logic [TUBE_BITS-1:0] tube_seg,
    output logic                 frame_start
);

    // DIGIT_DIV must be at least 2 for the divider wrap to be meaningful.
    localparam int unsigned DIGIT_DIV = CLK_FREQ / (SCAN_HZ * 8);
    localparam int unsigned BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned DW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0]          div_q;
    logic                   tick;
    logic [2:0]             nidx_q;
    logic                   frame_tick;
    logic [TUBE_BITS-1:0]   lin    [1:7];
    logic [TUBE_BITS-1:0]   snap_q [1:7];
    logic                   lz_q;
    logic [BW-1:0]          bcnt_q;
    logic                   phase_q;
    logic [7:1]             zrun;
    logic [7:0]             blank;
    logic [TUBE_BITS-1:0]   cur_code;
    logic [TUBE_BITS-1:0]   lz_code;
    logic [TUBE_BITS-1:0]   show_code;
    logic [7:0]             sel_d;
    logic [TUBE_BITS-1:0]   seg_d;
    logic [7:0]             sel_q;
    logic [TUBE_BITS-1:0]   seg_q;
    logic                   fs_q;

    assign tick       = (div_q == DW'(DIGIT_DIV - 1));
    // nidx_q names the digit that the next tick will put on the bus.
    assign frame_tick = tick && (nidx_q == 3'd0);

    always_comb begin
        lin[1] = l1;
        lin[2] = l2;
        lin[3] = l3;
        lin[4] = l4;
        lin[5] = l5;
        lin[6] = l6;
        lin[7] = l7;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nidx_q <= 3'd0;
        end else if (tick) begin
            nidx_q <= nidx_q + 3'd1;
        end
    end

    // Digit 0 is shown straight from l0 on the load tick, so only 1..7 are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 8; i++) begin
                snap_q[i] <= SEG_EMP;
            end
            lz_q <= 1'b0;
        end else if (frame_tick) begin
            for (int i = 1; i < 8; i++) begin
                snap_q[i] <= lin[i];
            end
            lz_q <= lz_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
        end else begin
            bcnt_q  <= bcnt_q + 1'b1;
        end
    end

    // A run of zeros from digit 7 downward; an empty code breaks the run.
    always_comb begin
        zrun     = '0;
        blank    = '0;
        zrun[7]  = (snap_q[7] == SEG_ZERO);
        for (int i = 6; i >= 1; i--) begin
            zrun[i] = zrun[i+1] && (snap_q[i] == SEG_ZERO);
        end
        for (int i = 1; i < 8; i++) begin
            blank[i] = lz_q && zrun[i];
        end
    end

    always_comb begin
        cur_code = l0;
        for (int i = 1; i < 8; i++) begin
            if (nidx_q == 3'(i)) begin
                cur_code = snap_q[i];
            end
        end
    end

    always_comb begin
        lz_code   = blank[nidx_q] ? SEG_EMP : cur_code;
        show_code = (!phase_q && blink_mask[nidx_q]) ? SEG_EMP : lz_code;
        sel_d     = 8'd0;
        seg_d     = SEG_EMP;
        if (scan_en) begin
            sel_d = 8'b1 << nidx_q;
            seg_d = show_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 8'd0;
            seg_q <= SEG_EMP;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= frame_tick;
            if (tick) begin
                sel_q <= sel_d;
                seg_q <= seg_d;
            end
        end
    end

    assign tube_sel    = sel_q;
    assign tube_seg    = seg_q;
    assign frame_start = fs_q;

endmodule
